// File: rtl/cnn_pkg.sv
// Shared CNN constants, FSM state encoding and the Q16.16 rescale/saturate helper.
// Used by both the convolution stage and the pooling stage.
package cnn_pkg;
  localparam int DATA_W = 32;
  localparam int FRAC   = 16;
  localparam int IN_W   = 8;
  localparam int K      = 3;
  localparam int OUT_W  = IN_W - K + 1;
  localparam int ACC_W  = 72;
  localparam int N_IN   = IN_W * IN_W;
  localparam int N_K    = K * K;
  localparam int N_OUT  = OUT_W * OUT_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_MAC,
    ST_WRITE,
    ST_NEXT
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Floor-shift out the fraction, clamp to the output range, then optional ReLU.
  function automatic logic signed [DATA_W-1:0] rescale_sat(input logic signed [ACC_W-1:0] acc,
                                                           input logic relu);
    logic signed [ACC_W-1:0] sh;
    logic signed [DATA_W-1:0] res;
    sh = acc >>> FRAC;
    if (sh > SAT_HI)      res = SAT_HI[DATA_W-1:0];
    else if (sh < SAT_LO) res = SAT_LO[DATA_W-1:0];
    else                  res = sh[DATA_W-1:0];
    if (relu && res < 0) res = '0;
    return res;
  endfunction
endpackage

// File: rtl/conv_layer_if.sv
// Start/done frame handshake plus the input map, kernel, bias and result map buses.
interface conv_layer_if;
  import cnn_pkg::*;

  logic                     start;
  logic signed [DATA_W-1:0] input_fm  [0:N_IN-1];
  logic signed [DATA_W-1:0] kernel    [0:N_K-1];
  logic signed [DATA_W-1:0] bias;
  logic                     busy;
  logic                     done;
  logic signed [DATA_W-1:0] output_fm [0:N_OUT-1];

  modport master (output start, input_fm, kernel, bias, input busy, done, output_fm);
  modport slave  (input start, input_fm, kernel, bias, output busy, done, output_fm);
endinterface

// File: rtl/conv_layer_mac_unit.sv
// Signed multiply-accumulate, 72-bit accumulator; clr loads init, en adds a*b.
// One result per cycle, no backpressure.
module mac_unit
  import cnn_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [ACC_W-1:0]  init,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);
  logic signed [2*DATA_W-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk) begin
    if (!rst)     acc <= '0;
    else if (clr) acc <= init;
    else if (en)  acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  end
endmodule

// File: rtl/conv_layer.sv
// 3x3 valid convolution of an 8x8 Q16.16 map, one MAC per cycle, 12 cycles per output.
// Frame latency 432 cycles from accepted start to done; start ignored while busy.
module conv_layer
  import cnn_pkg::*;
#(
  parameter bit RELU = 1'b1
) (
  input logic         clk,
  input logic         rst,
  conv_layer_if.slave bus
);
  state_t state, state_nxt;
  logic [2:0] r, c;
  logic [3:0] k;
  logic [3:0] k_sel;
  logic [5:0] fm_idx, out_idx;
  logic mac_clr, mac_en;
  logic signed [ACC_W-1:0] acc, bias_ext;

  assign bias_ext = {{(ACC_W-DATA_W-FRAC){bus.bias[DATA_W-1]}}, bus.bias, {FRAC{1'b0}}};
  // k runs one past the last tap on the final MAC edge; keep the kernel index in range.
  assign k_sel    = (k > 4'(N_K-1)) ? '0 : k;
  assign fm_idx   = 6'((32'(r) + 32'(k_sel) / K) * IN_W + 32'(c) + 32'(k_sel) % K);
  assign out_idx  = 6'(32'(r) * OUT_W + 32'(c));

  mac_unit u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr  (mac_clr),
    .en   (mac_en),
    .init (bias_ext),
    .a    (bus.input_fm[fm_idx]),
    .b    (bus.kernel[k_sel]),
    .acc  (acc)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_CLEAR;
      ST_CLEAR: begin
        mac_clr   = 1'b1;
        state_nxt = ST_MAC;
      end
      ST_MAC: begin
        mac_en = 1'b1;
        if (k == 4'(N_K-1)) state_nxt = ST_WRITE;
      end
      ST_WRITE: state_nxt = ST_NEXT;
      ST_NEXT: begin
        if (c == 3'(OUT_W-1) && r == 3'(OUT_W-1)) state_nxt = ST_IDLE;
        else                                      state_nxt = ST_CLEAR;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r        <= '0;
      c        <= '0;
      k        <= '0;
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
      for (int i = 0; i < N_OUT; i++) bus.output_fm[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
          bus.done <= 1'b0;
          bus.busy <= 1'b1;
          r        <= '0;
          c        <= '0;
        end
        ST_CLEAR: k <= '0;
        ST_MAC:   k <= k + 4'd1;
        ST_WRITE: bus.output_fm[out_idx] <= rescale_sat(acc, RELU);
        ST_NEXT: begin
          if (c < 3'(OUT_W-1)) begin
            c <= c + 3'd1;
          end else if (r < 3'(OUT_W-1)) begin
            c <= '0;
            r <= r + 3'd1;
          end else begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_layer.sv
// Drives a ReLU and a pass-through conv_layer with identical frames and checks both
// against a direct sliding-window arithmetic model.
module tb_conv_layer;
  import cnn_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv_layer_if ifr ();
  conv_layer_if ifp ();

  conv_layer #(.RELU(1'b1)) dut_r (.clk(clk), .rst(rst), .bus(ifr));
  conv_layer #(.RELU(1'b0)) dut_p (.clk(clk), .rst(rst), .bus(ifp));

  int n_chk  = 0;
  int n_fail = 0;

  logic signed [31:0] fm   [64];
  logic signed [31:0] kern [9];
  logic signed [31:0] bias_v;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected output pixel straight from the definition of a valid 3x3 convolution.
  function automatic logic signed [31:0] model(input int p, input bit relu);
    logic signed [71:0] acc, q;
    int r, c;
    r   = p / 6;
    c   = p % 6;
    acc = bias_v;
    acc = acc * 65536;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc += 72'(longint'(fm[(r+i)*8 + c+j]) * longint'(kern[i*3 + j]));
    q = acc / 65536;
    if (acc < 0 && q * 65536 != acc) q = q - 1;
    if (q > 72'sd2147483647)  q = 72'sd2147483647;
    if (q < -72'sd2147483648) q = -72'sd2147483648;
    if (relu && q < 0) q = 0;
    return q[31:0];
  endfunction

  task automatic apply();
    for (int i = 0; i < 64; i++) begin
      ifr.input_fm[i] = fm[i];
      ifp.input_fm[i] = fm[i];
    end
    for (int i = 0; i < 9; i++) begin
      ifr.kernel[i] = kern[i];
      ifp.kernel[i] = kern[i];
    end
    ifr.bias = bias_v;
    ifp.bias = bias_v;
  endtask

  task automatic set_start(input logic s);
    ifr.start = s;
    ifp.start = s;
  endtask

  task automatic kick(input bit hold);
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    #1;
    if (!hold) set_start(1'b0);
    check("busy_at_accept", ifr.busy, 1);
    check("done_at_accept", ifr.done, 0);
  endtask

  task automatic wait_done();
    int cyc = 0;
    bit busy_ok = 1'b1;
    while (ifr.done !== 1'b1 && cyc < 600) begin
      @(posedge clk);
      #1;
      cyc++;
      if (ifr.done !== 1'b1 && ifr.busy !== 1'b1) busy_ok = 1'b0;
    end
    check("done_latency", cyc, 432);
    check("busy_throughout", busy_ok, 1);
    check("busy_low_at_done", ifr.busy, 0);
    check("done_nonrelu_dut", ifp.done, 1);
  endtask

  task automatic check_outputs(input string tag);
    for (int p = 0; p < 36; p++) begin
      check({tag, "_relu"}, ifr.output_fm[p], model(p, 1'b1));
      check({tag, "_pass"}, ifp.output_fm[p], model(p, 1'b0));
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_done"}, ifr.done, 0);
    check({tag, "_busy"}, ifr.busy, 0);
    for (int p = 0; p < 36; p++) begin
      check({tag, "_out_relu"}, ifr.output_fm[p], 0);
      check({tag, "_out_pass"}, ifp.output_fm[p], 0);
    end
  endtask

  task automatic fill(input int fm_v, input int k_v, input int b_v);
    for (int i = 0; i < 64; i++) fm[i] = fm_v;
    for (int i = 0; i < 9; i++) kern[i] = k_v;
    bias_v = b_v;
  endtask

  task automatic fill_random(input bit full);
    for (int i = 0; i < 64; i++)
      fm[i] = full ? $urandom : int'($urandom_range(0, 1048575)) - 524288;
    for (int i = 0; i < 9; i++)
      kern[i] = full ? $urandom : int'($urandom_range(0, 262143)) - 131072;
    bias_v = full ? $urandom : int'($urandom_range(0, 1048575)) - 524288;
  endtask

  initial begin
    set_start(1'b0);
    fill(0, 0, 0);
    apply();
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b1;

    // Identity kernel: each output is the centre pixel of its window.
    for (int i = 0; i < 64; i++) fm[i] = i * 65536;
    for (int i = 0; i < 9; i++) kern[i] = 0;
    kern[4] = 65536;
    bias_v  = 0;
    apply();
    kick(1'b0);
    wait_done();
    check_outputs("identity");
    check("identity_p0", ifr.output_fm[0], 9 * 65536);
    check("identity_p35", ifr.output_fm[35], 54 * 65536);

    fill(65536, 65536, 32768);
    apply();
    kick(1'b0);
    wait_done();
    check_outputs("ones_bias_half");
    check("ones_p7", ifr.output_fm[7], 622592);

    fill(65536, -65536, 0);
    apply();
    kick(1'b0);
    wait_done();
    check_outputs("neg_kernel");
    check("neg_relu_p20", ifr.output_fm[20], 0);
    check("neg_pass_p20", ifp.output_fm[20], -589824);

    fill(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
    apply();
    kick(1'b0);
    wait_done();
    check_outputs("sat_pos");
    check("sat_pos_p13", ifp.output_fm[13], 64'sd2147483647);

    fill(32'h7FFF_FFFF, 32'h8000_0000, 0);
    apply();
    kick(1'b0);
    wait_done();
    check_outputs("sat_neg");
    check("sat_neg_pass_p0", ifp.output_fm[0], -64'sd2147483648);
    check("sat_neg_relu_p0", ifr.output_fm[0], 0);

    // Reset in the middle of a frame discards it entirely.
    fill_random(1'b0);
    apply();
    kick(1'b0);
    repeat (99) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_cleared("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    kick(1'b0);
    wait_done();
    check_outputs("after_reset");

    // Start held high: ignored while busy, then restarts straight after done.
    fill_random(1'b0);
    apply();
    kick(1'b1);
    wait_done();
    check_outputs("held_first");
    @(posedge clk);
    #1;
    check("held_restart_done", ifr.done, 0);
    check("held_restart_busy", ifr.busy, 1);
    set_start(1'b0);
    wait_done();
    check_outputs("held_second");

    for (int n = 0; n < 2; n++) begin
      fill_random(n == 0);
      apply();
      kick(1'b0);
      wait_done();
      check_outputs("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
